// File: rtl/jailbreak_pkg.sv
// Shared types for the dataslot command arbiter: FSM states, error codes and
// the command record that is latched from the winning requester.
package jailbreak_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_COMPLETE
    } arb_state_t;

    localparam logic [2:0] ERR_NONE        = 3'b000;
    localparam logic [2:0] ERR_ACK_TIMEOUT = 3'b111;

    typedef struct packed {
        logic        write;
        logic [15:0] id;
        logic [31:0] slotoffset;
        logic [31:0] bridgeaddr;
        logic [31:0] length;
    } dataslot_cmd_t;

    function automatic dataslot_cmd_t pack_cmd(
        input logic        write,
        input logic [15:0] id,
        input logic [31:0] slotoffset,
        input logic [31:0] bridgeaddr,
        input logic [31:0] length
    );
        dataslot_cmd_t c;
        c.write      = write;
        c.id         = id;
        c.slotoffset = slotoffset;
        c.bridgeaddr = bridgeaddr;
        c.length     = length;
        return c;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches upward from the index after
// last_idx, wrapping at NUM_REQ-1, and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

    always_comb begin : pick
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        logic             found;
        grant     = '0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        found     = 1'b0;
        // i = NUM_REQ lands back on last_idx, so the previous owner is tried last
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last_idx} + (IDX_W+1)'(i);
            if (sum >= NUM_W) begin
                sum = sum - NUM_W;
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/target_dataslot_arbiter.sv
// Shares one bridge dataslot command channel among NUM_REQ requesters:
// round-robin grant, clean strobe edge, ack timeout, and a done/err pulse back.
module target_dataslot_arbiter
    import jailbreak_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                     clk_74a,
    input  logic                     reset,

    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][15:0] req_id,
    input  logic [NUM_REQ-1:0][31:0] req_slotoffset,
    input  logic [NUM_REQ-1:0][31:0] req_bridgeaddr,
    input  logic [NUM_REQ-1:0][31:0] req_length,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [2:0]               req_err,

    output logic                     target_dataslot_read,
    output logic                     target_dataslot_write,
    output logic [15:0]              target_dataslot_id,
    output logic [31:0]              target_dataslot_slotoffset,
    output logic [31:0]              target_dataslot_bridgeaddr,
    output logic [31:0]              target_dataslot_length,
    input  logic                     target_dataslot_ack,
    input  logic                     target_dataslot_done,
    input  logic [2:0]               target_dataslot_err,

    output arb_state_t               fsm_state
);

    // Requester side: req_valid is a level held until req_done; the command
    // handler sees a strobe that stays high until ack, then done/err follow.
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t         state;
    dataslot_cmd_t      cmd;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   cur_idx;
    logic [CNT_W-1:0]   ack_cnt;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .last_idx  (last_idx),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state                 <= ST_IDLE;
            cmd                   <= '0;
            last_idx              <= LAST_INIT;
            cur_idx               <= '0;
            ack_cnt               <= '0;
            req_grant             <= '0;
            req_done              <= '0;
            req_err               <= ERR_NONE;
            target_dataslot_read  <= 1'b0;
            target_dataslot_write <= 1'b0;
        end else begin
            req_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        cmd <= pack_cmd(req_write[pick_idx], req_id[pick_idx],
                                        req_slotoffset[pick_idx], req_bridgeaddr[pick_idx],
                                        req_length[pick_idx]);
                        req_grant <= pick_grant;
                        cur_idx   <= pick_idx;
                        req_err   <= ERR_NONE;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // strobes were low for this whole cycle, so the edge is clean
                    target_dataslot_read  <= !cmd.write;
                    target_dataslot_write <= cmd.write;
                    ack_cnt               <= '0;
                    state                 <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (target_dataslot_ack) begin
                        target_dataslot_read  <= 1'b0;
                        target_dataslot_write <= 1'b0;
                        state                 <= ST_WAIT_DONE;
                    end else if (ack_cnt == CNT_LAST) begin
                        target_dataslot_read  <= 1'b0;
                        target_dataslot_write <= 1'b0;
                        req_err               <= ERR_ACK_TIMEOUT;
                        req_done              <= req_grant;
                        state                 <= ST_COMPLETE;
                    end else begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (target_dataslot_done) begin
                        req_err  <= target_dataslot_err;
                        req_done <= req_grant;
                        state    <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    // req_done is high during this cycle; next cycle may rearbitrate
                    req_grant <= '0;
                    last_idx  <= cur_idx;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign target_dataslot_id         = cmd.id;
    assign target_dataslot_slotoffset = cmd.slotoffset;
    assign target_dataslot_bridgeaddr = cmd.bridgeaddr;
    assign target_dataslot_length     = cmd.length;
    assign fsm_state                  = state;

endmodule

// File: tb/tb_target_dataslot_arbiter.sv
// Bench for target_dataslot_arbiter: table of commands plus hand sequences for
// ack timeout, valid drop and reset abort, checked through a completion queue.
module tb_target_dataslot_arbiter;
    import jailbreak_pkg::*;

    localparam int NUM_REQ     = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam int W           = 128;

    // ---------------- clock / reset ----------------
    logic clk_74a = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_74a = ~clk_74a;

    logic [NUM_REQ-1:0]       req_valid      = '0;
    logic [NUM_REQ-1:0]       req_write      = '0;
    logic [NUM_REQ-1:0][15:0] req_id         = '0;
    logic [NUM_REQ-1:0][31:0] req_slotoffset = '0;
    logic [NUM_REQ-1:0][31:0] req_bridgeaddr = '0;
    logic [NUM_REQ-1:0][31:0] req_length     = '0;
    logic [NUM_REQ-1:0]       req_grant;
    logic [NUM_REQ-1:0]       req_done;
    logic [2:0]               req_err;
    logic                     rd, wr;
    logic [15:0]              t_id;
    logic [31:0]              t_off, t_baddr, t_len;
    logic                     tb_ack  = 1'b0;
    logic                     tb_done = 1'b0;
    logic [2:0]               tb_err  = 3'b000;
    arb_state_t               fsm_state;

    target_dataslot_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk_74a                    (clk_74a),
        .reset                      (reset),
        .req_valid                  (req_valid),
        .req_write                  (req_write),
        .req_id                     (req_id),
        .req_slotoffset             (req_slotoffset),
        .req_bridgeaddr             (req_bridgeaddr),
        .req_length                 (req_length),
        .req_grant                  (req_grant),
        .req_done                   (req_done),
        .req_err                    (req_err),
        .target_dataslot_read       (rd),
        .target_dataslot_write      (wr),
        .target_dataslot_id         (t_id),
        .target_dataslot_slotoffset (t_off),
        .target_dataslot_bridgeaddr (t_baddr),
        .target_dataslot_length     (t_len),
        .target_dataslot_ack        (tb_ack),
        .target_dataslot_done       (tb_done),
        .target_dataslot_err        (tb_err),
        .fsm_state                  (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    // record: {done_vec, err, write, strobe_edges, strobe_high_cycles, id, len, off, baddr}
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    int           cmd_base = 0;
    int           mon_edges, mon_hi;
    logic         mon_prev, mon_kind;
    logic [W-1:0] mon_act, mon_exp;

    typedef struct {
        logic [1:0]  mask;
        int          win;
        logic        wr;
        logic [15:0] id;
        logic [31:0] len;
        int          ack_dly;
        int          done_dly;
        logic [2:0]  err;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [W-1:0] make_rec(input logic [1:0] dv, input logic [2:0] err,
                                              input logic wrb, input logic [1:0] edges,
                                              input logic [7:0] hi, input logic [15:0] id,
                                              input logic [31:0] len, input logic [31:0] off,
                                              input logic [31:0] baddr);
        return {dv, err, wrb, edges, hi, id, len, off, baddr};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: invariants and completion pop ----------------
    always @(negedge clk_74a) begin
        if (reset) begin
            mon_edges = 0;
            mon_hi    = 0;
            mon_prev  = 1'b0;
            mon_kind  = 1'b0;
        end else begin
            check("one_strobe", W'(rd & wr), W'(0));
            check("grant_onehot", W'($onehot0(req_grant)), W'(1));
            if ((rd | wr) && !mon_prev) begin
                mon_edges++;
                mon_kind = wr;
            end
            if (rd | wr) mon_hi++;
            mon_prev = rd | wr;
            if (|req_done) begin
                done_cnt++;
                mon_act = make_rec(req_done, req_err, mon_kind, mon_edges[1:0], mon_hi[7:0],
                                   t_id, t_len, t_off, t_baddr);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: req_done=%b with nothing pending", req_done);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("completion", mon_act, mon_exp);
                end
                mon_edges = 0;
                mon_hi    = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_74a);
        #1;
    endtask

    task automatic launch(input logic [1:0] mask, input int win, input logic wrb,
                          input logic [15:0] id, input logic [31:0] len,
                          input logic [2:0] err, input int hi, input bit push);
        logic [1:0] dv;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_write[i]      = (i == win) ? wrb : 1'($urandom_range(0, 1));
            req_id[i]         = (i == win) ? id : 16'($urandom);
            req_length[i]     = (i == win) ? len : $urandom;
            req_slotoffset[i] = $urandom;
            req_bridgeaddr[i] = $urandom;
        end
        req_valid = mask;
        dv        = '0;
        dv[win]   = 1'b1;
        cmd_base  = done_cnt;
        if (push) begin
            exp_q.push_back(make_rec(dv, err, wrb, 2'd1, 8'(hi), id, len,
                                     req_slotoffset[win], req_bridgeaddr[win]));
        end
    endtask

    task automatic wait_strobe(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            step();
            if (rd | wr) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_strobe: got no strobe expected strobe within 64 cycles", name);
        end
        // the handler keeps done high until it sees the next command
        tb_done = 1'b0;
        tb_err  = 3'b000;
    endtask

    task automatic ack_done(input int ack_dly, input int done_dly, input logic [2:0] err);
        repeat (ack_dly) step();
        tb_ack = 1'b1;
        if (done_dly == 0) begin
            tb_done = 1'b1;
            tb_err  = err;
        end
        step();
        tb_ack = 1'b0;
        if (done_dly > 0) begin
            repeat (done_dly - 1) step();
            tb_done = 1'b1;
            tb_err  = err;
        end
    endtask

    task automatic wait_complete(input string name, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (done_cnt != cmd_base) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done: got no req_done expected req_done within %0d cycles", name, budget);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, W'(req_grant), W'(0));
        check({tag, "_done"},  W'(req_done),  W'(0));
        check({tag, "_err"},   W'(req_err),   W'(0));
        check({tag, "_rd"},    W'(rd),        W'(0));
        check({tag, "_wr"},    W'(wr),        W'(0));
        check({tag, "_id"},    W'(t_id),      W'(0));
        check({tag, "_off"},   W'(t_off),     W'(0));
        check({tag, "_baddr"}, W'(t_baddr),   W'(0));
        check({tag, "_len"},   W'(t_len),     W'(0));
        check({tag, "_state"}, W'(fsm_state), W'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected end before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    initial begin
        //             mask   win wr    id        len            ack done err
        vecs[0] = '{2'b01, 0, 1'b0, 16'd5,    32'h0000_0100, 3, 20, 3'b000};
        vecs[1] = '{2'b11, 1, 1'b1, 16'h1234, 32'h0000_0040, 1, 2,  3'b000};
        vecs[2] = '{2'b11, 0, 1'b0, 16'h00aa, 32'h0000_0008, 0, 0,  3'b000};
        vecs[3] = '{2'b11, 1, 1'b0, 16'hbeef, 32'h0000_0200, 2, 1,  3'b000};
        vecs[4] = '{2'b11, 0, 1'b1, 16'h0001, 32'h0000_0010, 0, 5,  3'b000};
        vecs[5] = '{2'b10, 1, 1'b1, 16'h0042, 32'h0000_1000, 1, 3,  3'b010};
        vecs[6] = '{2'b01, 0, 1'b1, 16'hffff, 32'hffff_ffff, 4, 1,  3'b101};
        vecs[7] = '{2'b11, 1, 1'b0, 16'h0007, 32'h0000_0000, 2, 0,  3'b011};

        repeat (3) step();
        check_zero("por");
        reset = 1'b0;
        step();

        foreach (vecs[k]) begin
            launch(vecs[k].mask, vecs[k].win, vecs[k].wr, vecs[k].id, vecs[k].len,
                   vecs[k].err, vecs[k].ack_dly + 1, 1'b1);
            wait_strobe("vec");
            ack_done(vecs[k].ack_dly, vecs[k].done_dly, vecs[k].err);
            wait_complete("vec", 64);
        end

        // no ack at all: strobe must stay up ACK_TIMEOUT cycles, then error out
        launch(2'b01, 0, 1'b0, 16'h0dd0, 32'h0000_0020, ERR_ACK_TIMEOUT, ACK_TIMEOUT, 1'b1);
        wait_strobe("timeout");
        wait_complete("timeout", 64);

        // requester 1 withdraws mid-command; it must still finish exactly once
        launch(2'b10, 1, 1'b1, 16'h0b0b, 32'h0000_0080, ERR_NONE, 3, 1'b1);
        wait_strobe("drop");
        req_valid = '0;
        ack_done(2, 4, ERR_NONE);
        wait_complete("drop", 64);
        repeat (10) step();
        check("drop_single_done", W'(done_cnt - cmd_base), W'(1));
        check("drop_idle", W'(fsm_state), W'(ST_IDLE));

        // reset while waiting for done: abort without a completion pulse
        launch(2'b01, 0, 1'b1, 16'h0c0c, 32'h0000_0004, ERR_NONE, 1, 1'b0);
        wait_strobe("rst");
        tb_ack = 1'b1;
        step();
        tb_ack = 1'b0;
        step();
        check("rst_in_wait_done", W'(fsm_state), W'(ST_WAIT_DONE));
        reset = 1'b1;
        req_valid = 2'b11;
        step();
        check_zero("rst_mid");
        reset = 1'b0;
        launch(2'b11, 0, 1'b0, 16'h0d0d, 32'h0000_0300, 3'b001, 2, 1'b1);
        wait_strobe("post_rst");
        ack_done(1, 2, 3'b001);
        wait_complete("post_rst", 64);
        req_valid = '0;

        repeat (5) step();
        check("queue_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/target_dataslot_arbiter.md
TARGET_DATASLOT_ARBITER -- requirements
Module: target_dataslot_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1024, cycles allowed from command issue to target_dataslot_ack.
REQ-003 SHALL have port clk_74a, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, [NUM_REQ], per-requester level request; held high until that requester's req_done.
REQ-006 SHALL have port req_write, input, [NUM_REQ], 1 = dataslot write, 0 = dataslot read.
REQ-007 SHALL have port req_id, input, [NUM_REQ][16], dataslot id.
REQ-008 SHALL have port req_slotoffset, input, [NUM_REQ][32], byte offset in slot.
REQ-009 SHALL have port req_bridgeaddr, input, [NUM_REQ][32], bridge address.
REQ-010 SHALL have port req_length, input, [NUM_REQ][32], byte length.
REQ-011 SHALL have port req_grant, output, [NUM_REQ], one-hot; high while a requester owns the channel.
REQ-012 SHALL have port req_done, output, [NUM_REQ], one-cycle completion pulse.
REQ-013 SHALL have port req_err, output, 3, error code; valid in the req_done cycle.
REQ-014 SHALL have ports target_dataslot_read and target_dataslot_write, output, 1 each, command strobes to the bridge command handler.
REQ-015 SHALL have ports target_dataslot_id (16), target_dataslot_slotoffset (32), target_dataslot_bridgeaddr (32) and target_dataslot_length (32), all outputs, carrying the registered command parameters.
REQ-016 SHALL have ports target_dataslot_ack, target_dataslot_done (inputs, 1) and target_dataslot_err (input, 3), the handler's handshake.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, COMPLETE.
REQ-018 SHALL, in IDLE with any req_valid set, choose a winner round-robin, starting after the last granted index with wrap from NUM_REQ-1 to 0; it SHALL latch that requester's parameters into the target_dataslot_* outputs, set req_grant, and go to ISSUE.
REQ-019 SHALL hold the parameter outputs stable from ISSUE through COMPLETE.
REQ-020 SHALL, in ISSUE, spend one cycle with both strobes low so the handler sees a clean rising edge; it then asserts read or write per req_write and goes to WAIT_ACK.
REQ-021 SHALL hold the strobe high in WAIT_ACK until the first cycle target_dataslot_ack=1, then drop it and go to WAIT_DONE.
REQ-022 SHALL count from 0 in WAIT_ACK; if the count reaches ACK_TIMEOUT-1 without ack, it drops the strobe and goes to COMPLETE with req_err=3'b111.
REQ-023 SHALL, in WAIT_DONE on target_dataslot_done=1, latch target_dataslot_err into req_err and go to COMPLETE.
REQ-024 SHALL, in COMPLETE, pulse req_done of the granted index for one cycle, clear req_grant, update the round-robin pointer, and return to IDLE. Rearbitration is then possible the next cycle.
REQ-025 SHALL assert at most one strobe at a time and at most one req_grant bit at a time.
REQ-026 SHALL ignore a deassertion of the granted req_valid mid-operation; the command still completes and req_done still pulses.
REQ-027 SHALL ignore ack and done that arrive while in IDLE or ISSUE.
REQ-028 SHALL treat ack and done seen in the same WAIT_ACK cycle as ack only; done is then sampled in WAIT_DONE, because the handler holds done until the next command.

Reset
REQ-029 SHALL, on reset: FSM=IDLE; req_grant=0, req_done=0, req_err=0; both strobes=0; all target_dataslot_* parameters=0; round-robin pointer=NUM_REQ-1, so requester 0 wins first; timeout counter=0.
REQ-030 SHALL let reset mid-command abort immediately, with no req_done pulse.

Structure
REQ-031 SHALL take the FSM state enum, the error code 3'b111 (ERR_ACK_TIMEOUT) and a dataslot command struct (write, id, slotoffset, bridgeaddr, length) from the jailbreak package.
REQ-032 SHALL place the round-robin pick in one sub-module, rr_arbiter, which takes a request vector and a last-grant index and returns a one-hot grant and its index.

Verification
REQ-033 SHALL cover: req0 read id=5, len=0x100; ack after 3 cycles, done after 20 with err=0 -> one read rising edge, req_done[0] pulse, req_err=0.
REQ-034 SHALL cover: req0 and req1 high together, held -> grants alternate 0,1,0,1 across four commands.
REQ-035 SHALL cover: ack never arrives, ACK_TIMEOUT=16 -> strobe drops after 16 cycles, req_done pulses with req_err=3'b111.
REQ-036 SHALL cover: handler returns err=3'b010 -> req_err=3'b010 in the req_done cycle.
REQ-037 SHALL cover: reset asserted in WAIT_DONE -> all outputs zero next cycle, no req_done, requester 0 wins after reset.
REQ-038 SHALL cover: req1 drops valid during WAIT_ACK -> command completes, req_done[1] pulses once.
